// File: rtl/calc_pkg.sv
// calc_pkg: FSM states, status codes and keypad command codes shared by calc_param.
package calc_pkg;
  typedef enum logic [2:0] {A_ENTRY, B_ENTRY, CALC, MUL, DIV, PRINT, ERR} state_t;
  localparam logic [1:0] ST_ERR = 2'b00, ST_BUSY = 2'b01, ST_READY = 2'b10, ST_PRINT = 2'b11;
  localparam logic [3:0] CMD_ADD = 4'd10, CMD_SUB = 4'd11, CMD_MUL = 4'd12, CMD_DIV = 4'd13;
  localparam logic [3:0] CMD_EQ = 4'd14, CMD_BKSP = 4'd15;
endpackage

// File: rtl/calc_digit_out.sv
// calc_digit_out: streams a loaded magnitude as DIGITS BCD digits, LSD first, with position.
module calc_digit_out #(
  parameter int DIGITS = 8,
  localparam int VW = 4 * DIGITS,
  localparam int PW = $clog2(DIGITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [VW-1:0] mag,
  input  logic          sign,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          neg,
  output logic          done
);
  logic [VW-1:0] m;
  logic busy;
  assign data = 4'(m % VW'(10));
  assign done = busy && pos == PW'(DIGITS - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      m <= '0;
      pos <= '0;
      neg <= 1'b0;
      busy <= 1'b0;
    end else if (load) begin
      m <= mag;
      pos <= '0;
      neg <= sign;
      busy <= 1'b1;
    end else if (busy) begin
      m <= m / VW'(10);
      pos <= done ? '0 : pos + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/calc_param.sv
// calc_param: keypad calculator with decimal sign-magnitude operands and LSD-first digit streaming.
// Define CALC_DIV_EN to add restoring division on command 13.
module calc_param
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  localparam int VW = 4 * DIGITS,
  localparam int PW = $clog2(DIGITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          neg
);
  localparam int CW = PW + 2;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  function automatic logic [VW-1:0] max_val();
    logic [VW-1:0] v;
    v = VW'(1);
    for (int i = 0; i < DIGITS; i++) v = (v << 3) + (v << 1);
    return v - VW'(1);
  endfunction
  localparam logic [VW-1:0] MAXV = max_val();
  localparam logic [VW-1:0] FULLV = MAXV / VW'(10);
  localparam logic [2*VW-1:0] MAXW = {{VW{1'b0}}, MAXV};
  logic [1:0] rs;
  logic rst_n;
  state_t state, state_n, ret, ret_n;
  logic [VW-1:0] a_mag, a_n, b_mag, b_n, cur, nv, dig, ld_mag;
  logic a_neg, an_n, b_any, bany_n, held, held_n, rdy, rdy_n, ld, ld_neg;
  logic [3:0] op, op_n;
  logic [2*VW-1:0] acc, acc_n, mul_n, step, res;
  logic [CW-1:0] cnt, cnt_n;
  logic [VW:0] msum;
  logic signed [VW+1:0] sa, sb, sum;
  logic [VW+1:0] as_mag;
  logic accept, in_a, is_dig, is_op, fresh, skip, ovf, res_neg, done, sn;
  logic [3:0] sd;
  logic [PW-1:0] sp;
  // Reset asserts immediately but releases two clocks later.
  always_ff @(posedge clock or negedge reset)
    if (!reset) rs <= '0;
    else rs <= {rs[0], 1'b1};
  assign rst_n = rs[1];
  assign accept = cmd_valid && cmd_ready;
  assign in_a = state == A_ENTRY;
  assign is_dig = cmd < 4'd10;
  assign is_op = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_MUL || (DIV_EN && cmd == CMD_DIV);
  assign dig = {{(VW-4){1'b0}}, cmd};
  assign cur = in_a ? a_mag : b_mag;
  assign fresh = in_a && held && is_dig;
  assign skip = is_dig && cur > FULLV && !fresh;
  assign nv = fresh ? dig : is_dig ? (cur << 3) + (cur << 1) + dig : cur / VW'(10);
  assign sa = a_neg ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
  assign sb = $signed({2'b00, b_mag});
  assign sum = op == CMD_SUB ? sa - sb : sa + sb;
  assign as_mag = sum[VW+1] ? -sum : sum;
  // Shift-add: accumulator high half gains A when the multiplier LSB is set, then shifts right.
  assign msum = {1'b0, acc[2*VW-1:VW]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign mul_n = {msum, acc[VW-1:1]};
`ifdef CALC_DIV_EN
  logic [VW:0] t;
  logic ge;
  logic [2*VW-1:0] div_n;
  assign t = {acc[2*VW-1:VW], acc[VW-1]};
  assign ge = t >= {1'b0, b_mag};
  assign div_n = {ge ? t[VW-1:0] - b_mag : t[VW-1:0], acc[VW-2:0], ge};
  assign step = state == DIV ? div_n : mul_n;
`else
  assign step = mul_n;
`endif
  assign res = state == CALC ? {{(VW-2){1'b0}}, as_mag} : state == DIV ? {{VW{1'b0}}, step[VW-1:0]} : step;
  assign res_neg = (state == CALC ? sum[VW+1] : a_neg) && res != '0;
  assign ovf = res > MAXW;
  always_comb begin
    state_n = state;
    ret_n = ret;
    a_n = a_mag;
    an_n = a_neg;
    b_n = b_mag;
    bany_n = b_any;
    held_n = held;
    op_n = op;
    acc_n = acc;
    cnt_n = cnt;
    ld = 1'b0;
    ld_mag = nv;
    ld_neg = 1'b0;
    case (state)
      A_ENTRY, B_ENTRY: if (accept) begin
        if ((is_dig || cmd == CMD_BKSP) && !skip) begin
          if (in_a) begin
            a_n = nv;
            an_n = a_neg && !fresh && nv != '0;
            held_n = 1'b0;
            ld_neg = an_n;
          end else begin
            b_n = nv;
            bany_n = b_any || is_dig;
          end
          ld = 1'b1;
          ret_n = state;
          state_n = PRINT;
        end else if (is_op) begin
          if (in_a) begin
            op_n = cmd;
            b_n = '0;
            bany_n = 1'b0;
            held_n = 1'b0;
            state_n = B_ENTRY;
          end else state_n = ERR;
        end else if (cmd == CMD_EQ && !in_a) begin
          if (!b_any || (op == CMD_DIV && b_mag == '0)) state_n = ERR;
          else begin
            state_n = op == CMD_MUL ? MUL : op == CMD_DIV ? DIV : CALC;
            acc_n = {{VW{1'b0}}, op == CMD_DIV ? a_mag : b_mag};
            cnt_n = '0;
          end
        end
      end
      CALC, MUL, DIV: begin
        acc_n = step;
        cnt_n = cnt + 1'b1;
        if (state == CALC || cnt == CW'(VW - 1)) begin
          if (ovf) state_n = ERR;
          else begin
            a_n = res[VW-1:0];
            an_n = res_neg;
            b_n = '0;
            bany_n = 1'b0;
            held_n = 1'b1;
            ld = 1'b1;
            ld_mag = res[VW-1:0];
            ld_neg = res_neg;
            ret_n = A_ENTRY;
            state_n = PRINT;
          end
        end
      end
      PRINT: if (done) state_n = ret;
      default: ;
    endcase
    rdy_n = (state_n == A_ENTRY || state_n == B_ENTRY) && !accept;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state <= A_ENTRY;
      ret <= A_ENTRY;
      a_mag <= '0;
      a_neg <= 1'b0;
      b_mag <= '0;
      b_any <= 1'b0;
      held <= 1'b0;
      op <= '0;
      acc <= '0;
      cnt <= '0;
      rdy <= 1'b1;
    end else begin
      state <= state_n;
      ret <= ret_n;
      a_mag <= a_n;
      a_neg <= an_n;
      b_mag <= b_n;
      b_any <= bany_n;
      held <= held_n;
      op <= op_n;
      acc <= acc_n;
      cnt <= cnt_n;
      rdy <= rdy_n;
    end
  calc_digit_out #(.DIGITS(DIGITS)) u_out (
    .clock(clock),
    .reset(rst_n),
    .load(ld),
    .mag(ld_mag),
    .sign(ld_neg),
    .data(sd),
    .pos(sp),
    .neg(sn),
    .done(done)
  );
  assign cmd_ready = rdy;
  assign status = state == ERR ? ST_ERR : state == PRINT ? ST_PRINT :
                  (state == CALC || state == MUL || state == DIV) ? ST_BUSY : ST_READY;
  assign data = state == PRINT ? sd : 4'd0;
  assign pos = state == PRINT ? sp : '0;
  assign neg = state == PRINT && sn;
endmodule

// File: tb/tb_calc_param.sv
// tb_calc_param: directed and random keypad sequences checked cycle by cycle against a
// sign-magnitude calculator model.
module tb_calc_param;
  import calc_pkg::*;
  localparam int DIGITS = 4;
  localparam int VW = 4 * DIGITS;
  localparam int PW = $clog2(DIGITS);
  localparam longint LIM = 10000;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef struct packed {logic [1:0] st; logic [3:0] d; logic [PW-1:0] p; logic n;} smp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] cmd = '0;
  logic cmd_valid = 1'b0;
  logic cmd_ready, neg;
  logic [1:0] status;
  logic [3:0] data;
  logic [PW-1:0] pos;
  int total = 0, bad = 0;
  smp_t exp_q[$], got_q[$];
  longint am, bm;
  bit an, b_any, held, in_b, err;
  int op;

  calc_param #(.DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .status(status), .data(data), .pos(pos), .neg(neg)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic smp_t mk(logic [1:0] st, logic [3:0] d, logic [PW-1:0] p, logic n);
    smp_t s;
    s.st = st; s.d = d; s.p = p; s.n = n;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    am = 0; bm = 0; an = 0; b_any = 0; held = 0; in_b = 0; err = 0; op = 0;
  endtask

  // Builds the expected per-cycle status trace that follows acceptance of key c.
  task automatic model_key(input int c);
    longint r, sa, pv;
    int nb;
    bit pr, ng, fail;
    exp_q.delete();
    nb = 0; pr = 0; ng = 0; fail = 0; pv = 0;
    if (c < 10 || c == 15) begin
      if (!in_b) begin
        if (c == 15) begin am = am / 10; held = 0; pr = 1; end
        else if (held) begin am = c; an = 0; held = 0; pr = 1; end
        else if (am < LIM / 10) begin am = am * 10 + c; pr = 1; end
        an = an && am != 0;
        pv = am; ng = an;
      end else begin
        if (c == 15) begin bm = bm / 10; pr = 1; end
        else if (bm < LIM / 10) begin bm = bm * 10 + c; b_any = 1; pr = 1; end
        pv = bm;
      end
    end else if (c == 13 && !DIV_EN) begin
      pr = 0;
    end else if (c != 14) begin
      if (in_b) fail = 1;
      else begin op = c; bm = 0; b_any = 0; held = 0; in_b = 1; end
    end else if (in_b) begin
      if (!b_any || (op == 13 && bm == 0)) fail = 1;
      else begin
        sa = an ? -am : am;
        r = op == 10 ? sa + bm : op == 11 ? sa - bm : op == 12 ? sa * bm : sa / bm;
        nb = op < 12 ? 1 : VW;
        if (r >= LIM || r <= -LIM) fail = 1;
        else begin
          am = r < 0 ? -r : r; an = r < 0;
          bm = 0; b_any = 0; held = 1; in_b = 0;
          pr = 1; pv = am; ng = an;
        end
      end
    end
    for (int i = 0; i < nb; i++) exp_q.push_back(mk(ST_BUSY, 4'd0, '0, 1'b0));
    if (pr) for (int i = 0; i < DIGITS; i++) begin
      exp_q.push_back(mk(ST_PRINT, 4'(pv % 10), PW'(i), ng));
      pv = pv / 10;
    end
    exp_q.push_back(mk(fail ? ST_ERR : ST_READY, 4'd0, '0, 1'b0));
    err = fail;
  endtask

  task automatic send(input int c);
    int w;
    w = 0;
    @(negedge clock);
    while (!cmd_ready && w < 50) begin @(negedge clock); w++; end
    chk("ready_wait", cmd_ready, 1);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic key(input int c);
    model_key(c);
    send(c);
    got_q.delete();
    do begin
      @(negedge clock);
      got_q.push_back(mk(status, data, pos, neg));
    end while (status != ST_READY && status != ST_ERR && got_q.size() < 64);
    chk($sformatf("trace_len key=%0d", c), got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) begin
      chk($sformatf("status key=%0d cyc=%0d", c, i), got_q[i].st, exp_q[i].st);
      if (exp_q[i].st == ST_PRINT || exp_q[i].st == ST_ERR) begin
        chk($sformatf("data key=%0d cyc=%0d", c, i), got_q[i].d, exp_q[i].d);
        chk($sformatf("pos key=%0d cyc=%0d", c, i), got_q[i].p, exp_q[i].p);
      end
      if (exp_q[i].st == ST_PRINT) chk($sformatf("neg key=%0d cyc=%0d", c, i), got_q[i].n, exp_q[i].n);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_status", status, ST_READY);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_data", data, 0);
    chk("rst_pos", pos, 0);
    chk("rst_neg", neg, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    model_reset();
  endtask

  task automatic raw(input int c, input int n, input logic [1:0] st);
    send(c);
    repeat (n) @(negedge clock);
    chk($sformatf("mid_status key=%0d", c), status, st);
  endtask

  initial begin
    int r, c;
    model_reset();
    do_reset();
    key(1); key(2); key(10); key(3); key(4); key(14);
    do_reset();
    key(5); key(11); key(1); key(2); key(14);
    key(12); key(3); key(14);
    do_reset();
    key(9); key(9); key(12); key(9); key(9); key(14);
    do_reset();
    key(9); key(9); key(9); key(9); key(12); key(2); key(14);
    chk("err_ready", cmd_ready, 0);
    cmd = 4'd1;
    cmd_valid = 1'b1;
    repeat (5) @(negedge clock);
    chk("err_hold_status", status, ST_ERR);
    chk("err_hold_ready", cmd_ready, 0);
    chk("err_hold_data", data, 0);
    cmd_valid = 1'b0;
    do_reset();
    key(1); key(2); key(3); key(4); key(5); key(15);
    do_reset();
`ifdef CALC_DIV_EN
    key(7); key(13); key(0); key(14);
    do_reset();
    key(8); key(5); key(13); key(4); key(14);
`else
    key(7); key(13); key(10); key(1); key(14);
`endif
    do_reset();
    key(3); key(12); key(4);
    raw(14, 6, ST_BUSY);
    do_reset();
    raw(5, 2, ST_PRINT);
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      c = r < 55 ? r % 10 : r < 70 ? 10 + r % 4 : r < 88 ? 14 : 15;
      if (err) do_reset();
      key(c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
